// File: rtl/mips_multicycle_control_pkg.sv
// Shared types and encodings for the multicycle MIPS control sequencer.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    IMM_EX   = 4'd8,
    IMM_WB   = 4'd9,
    LUI_WB   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    JR       = 4'd13,
    TRAP     = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  // States that hold until the unified memory signals completion.
  function automatic logic isMemWait(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control/status bundle between the multicycle sequencer (master) and the datapath (slave).
interface mips_multicycle_control_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_en;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        zero_imm;
  logic        lui;
  logic [1:0]  pc_source;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic        retire;
  logic        trap;
  logic        mem_timeout;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, zero_imm, lui, pc_source, alu_op,
           state, retire, trap, mem_timeout, cycle_count, retire_count
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, zero_imm, lui, pc_source, alu_op,
           state, retire, trap, mem_timeout, cycle_count, retire_count
  );
endinterface

// File: rtl/mips_multicycle_control_perf.sv
// Free-running cycle and retired-instruction counters, wrapping modulo 2^32.
module mc_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        countEn,
  input  logic        retire,
  output logic [31:0] cycleCount,
  output logic [31:0] retireCount
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCount  <= '0;
      retireCount <= '0;
    end else begin
      if (countEn) cycleCount  <= cycleCount + 32'd1;
      if (retire)  retireCount <= retireCount + 32'd1;
    end
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional performance counters are built when MC_PERF_COUNTERS_EN is defined.
module mips_multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  mips_multicycle_control_if.master  bus
);

  localparam int unsigned SW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [SW-1:0] LIMIT    = SW'(WAIT_TIMEOUT);
  localparam logic [SW-1:0] LIMIT_M1 = SW'(WAIT_TIMEOUT - 1);

  state_t state, nextState;

  logic       pcEn, iord, memRead, memWrite, irWrite, regDst, memToReg, regWrite;
  logic       aluSrcA, zeroImm, luiSel, retireC;
  logic [1:0] aluSrcB, pcSource;
  logic [2:0] aluOp;
  logic       waiting;
  logic [SW-1:0] stallCnt;
  logic       memTimeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    pcEn      = 1'b0;
    iord      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_RT;
    zeroImm   = 1'b0;
    luiSel    = 1'b0;
    pcSource  = PCSRC_ALU;
    aluOp     = ALU_ADD;
    retireC   = 1'b0;
    unique case (state)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        if (bus.mem_ready) begin
          irWrite   = 1'b1;
          pcEn      = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        aluSrcB = SRCB_IMM_SH2;
        unique case (bus.opcode)
          OP_RTYPE:                  nextState = (bus.funct == FN_JR) ? JR : RTYPE_EX;
          OP_LW, OP_SW:              nextState = MEMADR;
          OP_ADDI, OP_ANDI, OP_ORI:  nextState = IMM_EX;
          OP_LUI:                    nextState = LUI_WB;
          OP_BEQ, OP_BNE:            nextState = BRANCH;
          OP_J:                      nextState = JUMP;
          default:                   nextState = TRAP;
        endcase
      end
      MEMADR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_IMM;
        nextState = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        memRead = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) nextState = MEMWB;
      end
      MEMWB: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        retireC   = 1'b1;
        nextState = FETCH;
      end
      MEMWR: begin
        memWrite = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) begin
          retireC   = 1'b1;
          nextState = FETCH;
        end
      end
      RTYPE_EX: begin
        aluSrcA   = 1'b1;
        aluOp     = ALU_RTYPE;
        nextState = RTYPE_WB;
      end
      RTYPE_WB: begin
        regWrite  = 1'b1;
        regDst    = 1'b1;
        retireC   = 1'b1;
        nextState = FETCH;
      end
      IMM_EX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        if (bus.opcode == OP_ANDI) begin
          aluOp   = ALU_AND;
          zeroImm = 1'b1;
        end else if (bus.opcode == OP_ORI) begin
          aluOp   = ALU_OR;
          zeroImm = 1'b1;
        end
        nextState = IMM_WB;
      end
      IMM_WB: begin
        regWrite  = 1'b1;
        retireC   = 1'b1;
        nextState = FETCH;
      end
      LUI_WB: begin
        regWrite  = 1'b1;
        luiSel    = 1'b1;
        retireC   = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        aluSrcA   = 1'b1;
        aluOp     = ALU_SUB;
        pcSource  = PCSRC_ALUOUT;
        pcEn      = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
        retireC   = 1'b1;
        nextState = FETCH;
      end
      JUMP: begin
        pcSource  = PCSRC_JUMP;
        pcEn      = 1'b1;
        retireC   = 1'b1;
        nextState = FETCH;
      end
      JR: begin
        pcSource  = PCSRC_RS;
        pcEn      = 1'b1;
        retireC   = 1'b1;
        nextState = FETCH;
      end
      TRAP:    nextState = TRAP;
      default: nextState = FETCH;
    endcase
  end

  // Waiting states never change state while stalled, so clearing on
  // "not waiting" also covers every state change.
  assign waiting = isMemWait(state) && !bus.mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt   <= '0;
      memTimeout <= 1'b0;
    end else if (!waiting) begin
      stallCnt <= '0;
    end else begin
      if (stallCnt != LIMIT) stallCnt <= stallCnt + 1'b1;
      if ((WAIT_TIMEOUT != 0) && (stallCnt == LIMIT_M1)) memTimeout <= 1'b1;
    end
  end

  // Strobes are masked while reset is asserted so nothing is written mid-reset.
  assign bus.pc_en       = pcEn     & ~reset;
  assign bus.mem_read    = memRead  & ~reset;
  assign bus.mem_write   = memWrite & ~reset;
  assign bus.ir_write    = irWrite  & ~reset;
  assign bus.reg_write   = regWrite & ~reset;
  assign bus.retire      = retireC  & ~reset;
  assign bus.iord        = iord;
  assign bus.reg_dst     = regDst;
  assign bus.mem_to_reg  = memToReg;
  assign bus.alu_src_a   = aluSrcA;
  assign bus.alu_src_b   = aluSrcB;
  assign bus.zero_imm    = zeroImm;
  assign bus.lui         = luiSel;
  assign bus.pc_source   = pcSource;
  assign bus.alu_op      = aluOp;
  assign bus.state       = state;
  assign bus.trap        = (state == TRAP);
  assign bus.mem_timeout = memTimeout;

`ifdef MC_PERF_COUNTERS_EN
  mc_perf_counters uPerf (
    .clk         (clk),
    .reset       (reset),
    .countEn     (state != TRAP),
    .retire      (bus.retire),
    .cycleCount  (bus.cycle_count),
    .retireCount (bus.retire_count)
  );
`else
  assign bus.cycle_count  = '0;
  assign bus.retire_count = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for mips_multicycle_control (WAIT_TIMEOUT=4).
module tb_mips_multicycle_control;
  import mips_mc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] expCycles;
  logic [31:0] expRetires;

  always #5 clk = ~clk;

  mips_multicycle_control_if bus ();

  mips_multicycle_control #(.WAIT_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Set inputs for the current cycle and let combinational outputs settle.
  task automatic step(input logic ready, input logic z);
    bus.mem_ready = ready;
    bus.zero      = z;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_state",   bus.state, FETCH);
    chk("rst_memread", bus.mem_read, 1'b0);
    chk("rst_strobes", {bus.pc_en, bus.ir_write, bus.retire, bus.trap, bus.mem_timeout}, 5'b0);
    chk("rst_cycles",  bus.cycle_count, 32'd0);
    reset = 1'b0;

    // Ten zero-wait R-type instructions from reset.
    bus.opcode = 6'h00; bus.funct = 6'h20;
    for (int i = 0; i < 10; i++) begin
      step(1, 0);
      if (i == 0) begin
        chk("fetch_memread", bus.mem_read, 1'b1);
        chk("fetch_irw_pce", {bus.ir_write, bus.pc_en, bus.iord}, 3'b110);
        chk("fetch_srcb",    bus.alu_src_b, 2'd1);
      end
      tick(); step(1, 0);
      if (i == 0) chk("decode_srcb", {bus.state, bus.alu_src_b}, {4'd1, 2'd3});
      tick(); step(1, 0);
      if (i == 0) chk("rtype_ex", {bus.state, bus.alu_src_a, bus.alu_op}, {4'd6, 1'b1, 3'd7});
      tick(); step(1, 0);
      chk("rtype_wb", {bus.reg_write, bus.reg_dst, bus.retire}, 3'b111);
      tick();
    end
`ifdef MC_PERF_COUNTERS_EN
    expCycles = 32'd40; expRetires = 32'd10;
`else
    expCycles = 32'd0; expRetires = 32'd0;
`endif
    chk("cycle_count",  bus.cycle_count,  expCycles);
    chk("retire_count", bus.retire_count, expRetires);

    // addi: 4 cycles, retire in cycle 4.
    bus.opcode = 6'h08;
    step(1, 0); tick(); step(1, 0); tick(); step(1, 0);
    chk("addi_ex", {bus.state, bus.alu_op, bus.alu_src_b, bus.zero_imm}, {4'd8, 3'd0, 2'd2, 1'b0});
    tick(); step(1, 0);
    chk("addi_wb", {bus.state, bus.reg_write, bus.reg_dst, bus.retire}, {4'd9, 3'b101});
    tick();

    // ori uses zero-extended immediate and OR.
    bus.opcode = 6'h0D;
    step(1, 0); tick(); step(1, 0); tick(); step(1, 0);
    chk("ori_ex", {bus.alu_op, bus.zero_imm}, {3'd2, 1'b1});
    tick(); step(1, 0); tick();

    // lw with three wait cycles in MEMRD: 8 cycles total.
    bus.opcode = 6'h23;
    step(1, 0); tick(); step(1, 0); tick(); step(1, 0);
    chk("lw_memadr", {bus.state, bus.alu_src_a, bus.alu_src_b}, {4'd2, 1'b1, 2'd2});
    tick();
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      chk("lw_stall", {bus.state, bus.mem_read, bus.iord, bus.retire}, {4'd3, 3'b110});
      tick();
    end
    step(1, 0);
    chk("lw_memrd_go", bus.state, MEMRD);
    tick(); step(1, 0);
    chk("lw_memwb", {bus.state, bus.reg_write, bus.mem_to_reg, bus.reg_dst, bus.retire},
        {4'd4, 4'b1101});
    chk("lw_no_timeout", bus.mem_timeout, 1'b0);
    tick();

    // sw: retire in MEMWR gated by mem_ready.
    bus.opcode = 6'h2B;
    step(1, 0); tick(); step(1, 0); tick(); step(1, 0); tick(); step(0, 0);
    chk("sw_wait", {bus.state, bus.mem_write, bus.iord, bus.retire}, {4'd5, 3'b110});
    step(1, 0);
    chk("sw_done", {bus.mem_write, bus.retire}, 2'b11);
    tick();

    // beq with zero=1 then zero=0 in the BRANCH cycle.
    bus.opcode = 6'h04;
    step(1, 0); tick(); step(1, 0); tick(); step(1, 1);
    chk("beq_taken", {bus.state, bus.pc_en, bus.pc_source, bus.alu_op, bus.retire},
        {4'd11, 1'b1, 2'd1, 3'd1, 1'b1});
    step(1, 0);
    chk("beq_not", bus.pc_en, 1'b0);
    tick();

    // bne inverts the zero condition.
    bus.opcode = 6'h05;
    step(1, 0); tick(); step(1, 0); tick(); step(1, 0);
    chk("bne_taken", bus.pc_en, 1'b1);
    step(1, 1);
    chk("bne_not", bus.pc_en, 1'b0);
    tick();

    // j, jr, lui: 3 cycles each.
    bus.opcode = 6'h02;
    step(1, 0); tick(); step(1, 0); tick(); step(1, 0);
    chk("jump", {bus.state, bus.pc_source, bus.pc_en, bus.retire}, {4'd12, 2'd2, 2'b11});
    tick();
    bus.opcode = 6'h00; bus.funct = 6'h08;
    step(1, 0); tick(); step(1, 0); tick(); step(1, 0);
    chk("jr", {bus.state, bus.pc_source, bus.pc_en, bus.retire, bus.reg_write}, {4'd13, 2'd3, 3'b110});
    tick();
    bus.opcode = 6'h0F;
    step(1, 0); tick(); step(1, 0); tick(); step(1, 0);
    chk("lui", {bus.state, bus.lui, bus.reg_write, bus.reg_dst, bus.retire}, {4'd10, 4'b1101});
    tick();

    // FETCH stall: timeout flag appears after stall cycle 4.
    for (int i = 0; i < 3; i++) begin
      step(0, 0); tick();
    end
    step(0, 0);
    chk("timeout_pre", {bus.state, bus.mem_timeout, bus.ir_write}, {4'd0, 2'b00});
    tick(); step(0, 0);
    chk("timeout_set", {bus.state, bus.mem_timeout}, {4'd0, 1'b1});
    step(1, 0);
    tick(); step(1, 0);
    chk("timeout_resume", bus.state, DECODE);

    // Illegal opcode in DECODE traps and stays absorbing.
    bus.opcode = 6'h3F; bus.funct = 6'h00;
    #1;
    tick();
    for (int i = 0; i < 20; i++) begin
      step(1, i[0]);
      chk("trap_hold", {bus.state, bus.trap, bus.pc_en, bus.mem_read, bus.mem_write,
                        bus.ir_write, bus.reg_write, bus.retire}, {4'd14, 7'b1000000});
      tick();
    end

    // Asynchronous reset pulse mid-cycle.
    #2 reset = 1'b1;
    #1;
    chk("areset", {bus.state, bus.trap, bus.mem_timeout, bus.mem_read}, {4'd0, 3'b000});
    reset = 1'b0;
    #1;
    chk("areset_cycles", bus.cycle_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
